// File: rtl/shift_sequencer_pkg.sv
// Op codes and state encoding shared by the shift sequencer and the
// benches that drive the downstream universal shift register.
package shift_sequencer_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_NOP  = 2'b00;
  localparam op_t OP_SHR  = 2'b01;
  localparam op_t OP_SHL  = 2'b10;
  localparam op_t OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_DONE  = 2'b10
  } seq_state_t;

endpackage

// File: rtl/shift_sequencer.sv
// Command sequencer that drives sel/p_out/serial fill bits of a downstream
// universal shift register for load, right-shift and left-shift commands.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_DRIVE | one drive cycle per shift (or the single load cycle)
// ST_DONE  | one-cycle done pulse, then back to idle
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] p_out,
  output logic             serial_right,
  output logic             serial_left,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  // Shift counts above WIDTH are clamped so the counter can never wrap.
  function automatic logic [CNT_W-1:0] drive_cycles(input logic [1:0] op,
                                                    input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] n;
    case (op)
      OP_LOAD: n = ONE_C;
      OP_NOP:  n = '0;
      default: n = (cnt > WIDTH_C) ? WIDTH_C : cnt;
    endcase
    return n;
  endfunction

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic [1:0]       op_lat, op_nxt;
  logic [WIDTH-1:0] data_lat, data_nxt;

  logic [1:0]       sel_nxt;
  logic [WIDTH-1:0] p_nxt;
  logic             sr_nxt, sl_nxt, busy_nxt, done_nxt, ready_nxt;

  logic             accept;
  logic [CNT_W-1:0] n_eff;
  logic             drv_en;
  logic [1:0]       drv_op;
  logic [WIDTH-1:0] drv_word;

  assign accept = cmd_valid && cmd_ready && (state == ST_IDLE);
  assign n_eff  = drive_cycles(cmd_op, cmd_count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      rem          <= '0;
      op_lat       <= OP_NOP;
      data_lat     <= '0;
      sel          <= OP_NOP;
      p_out        <= '0;
      serial_right <= 1'b0;
      serial_left  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cmd_ready    <= 1'b0;
    end else begin
      state        <= state_nxt;
      rem          <= rem_nxt;
      op_lat       <= op_nxt;
      data_lat     <= data_nxt;
      sel          <= sel_nxt;
      p_out        <= p_nxt;
      serial_right <= sr_nxt;
      serial_left  <= sl_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      cmd_ready    <= ready_nxt;
    end
  end

  // Outputs are computed for the next state so that they appear registered
  // in the same cycle the state register enters that state.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    op_nxt    = op_lat;
    data_nxt  = data_lat;
    drv_en    = 1'b0;
    drv_op    = op_lat;
    drv_word  = data_lat;
    done_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          op_nxt = cmd_op;
          if (n_eff == '0) begin
            state_nxt = ST_DONE;
            rem_nxt   = '0;
            data_nxt  = cmd_data;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_DRIVE;
            rem_nxt   = n_eff - ONE_C;
            drv_en    = 1'b1;
            drv_op    = cmd_op;
            drv_word  = cmd_data;
            data_nxt  = cmd_data >> 1;
          end
        end
      end
      ST_DRIVE: begin
        if (rem == '0) begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
        end else begin
          rem_nxt  = rem - ONE_C;
          drv_en   = 1'b1;
          drv_word = data_lat;
          data_nxt = data_lat >> 1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    sel_nxt = OP_NOP;
    p_nxt   = '0;
    sr_nxt  = 1'b0;
    sl_nxt  = 1'b0;
    if (drv_en) begin
      sel_nxt = drv_op;
      case (drv_op)
        OP_LOAD: p_nxt  = drv_word;
        OP_SHR:  sr_nxt = drv_word[0];
        OP_SHL:  sl_nxt = drv_word[0];
        default: ;
      endcase
    end

    busy_nxt  = (state_nxt != ST_IDLE);
    ready_nxt = (state_nxt == ST_IDLE);
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized bench: sequencer driving a 4-bit universal shift register,
// checked cycle by cycle against a queue-based command model.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [2:0]   cmd_count;
  logic [W-1:0] cmd_data;
  logic [1:0]   sel;
  logic [W-1:0] p_out;
  logic         serial_right, serial_left, busy, done;
  logic [W-1:0] q;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(W), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data),
    .sel(sel), .p_out(p_out), .serial_right(serial_right),
    .serial_left(serial_left), .busy(busy), .done(done)
  );

  // downstream universal register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else case (sel)
      OP_SHR:  q <= {serial_right, q[W-1:1]};
      OP_SHL:  q <= {q[W-2:0], serial_left};
      OP_LOAD: q <= p_out;
      default: q <= q;
    endcase
  end

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] p;
    logic         sr, sl, busy, done, ready, chk_q;
    logic [W-1:0] q;
  } exp_t;

  exp_t         expq[$];
  logic         hold;
  logic         cur_ready;
  logic [W-1:0] q_model;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           drv_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff_cycles(input logic [1:0] op, input logic [2:0] cnt);
    if (op == OP_LOAD) return 1;
    if (op == OP_NOP) return 0;
    return (int'(cnt) > W) ? W : int'(cnt);
  endfunction

  // Register contents after a whole command, from plain arithmetic.
  function automatic logic [W-1:0] q_after(input logic [W-1:0] q0, input logic [1:0] op,
                                           input int n, input logic [W-1:0] d);
    int qi, di, r;
    qi = int'(q0);
    di = int'(d) & ((1 << n) - 1);
    case (op)
      OP_LOAD: return d;
      OP_SHR:  return W'((qi >> n) | (di << (W - n)));
      OP_SHL: begin
        r = 0;
        for (int k = 0; k < n; k++) if (d[k]) r |= (1 << (n - 1 - k));
        return W'((qi << n) | r);
      end
      default: return q0;
    endcase
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (sel != 2'b00) drv_seen++;
    if (expq.size() > 0) e = expq.pop_front();
    else e = '{sel: 2'b00, p: '0, sr: 1'b0, sl: 1'b0, busy: 1'b0, done: 1'b0,
               ready: !hold, chk_q: 1'b0, q: '0};
    check("sel",          32'(sel),          32'(e.sel));
    check("p_out",        32'(p_out),        32'(e.p));
    check("serial_right", 32'(serial_right), 32'(e.sr));
    check("serial_left",  32'(serial_left),  32'(e.sl));
    check("busy",         32'(busy),         32'(e.busy));
    check("done",         32'(done),         32'(e.done));
    check("cmd_ready",    32'(cmd_ready),    32'(e.ready));
    if (e.chk_q) check("q", 32'(q), 32'(e.q));
    cur_ready = e.ready;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [2:0] cnt,
                       input logic [W-1:0] d, output logic acc);
    exp_t e;
    int   n;
    cmd_valid = v; cmd_op = op; cmd_count = cnt; cmd_data = d;
    acc = cur_ready && v;
    if (acc) begin
      n = eff_cycles(op, cnt);
      for (int k = 0; k < n; k++) begin
        e = '{sel: op, p: (op == OP_LOAD) ? d : '0,
              sr: (op == OP_SHR) ? d[k] : 1'b0, sl: (op == OP_SHL) ? d[k] : 1'b0,
              busy: 1'b1, done: 1'b0, ready: 1'b0, chk_q: 1'b0, q: '0};
        expq.push_back(e);
      end
      q_model = q_after(q_model, op, n, d);
      e = '{sel: 2'b00, p: '0, sr: 1'b0, sl: 1'b0, busy: 1'b1, done: 1'b1,
            ready: 1'b0, chk_q: 1'b1, q: q_model};
      expq.push_back(e);
    end
  endtask

  task automatic rand_idle_inputs();
    logic acc;
    drive(1'b0, 2'($urandom), 3'($urandom), W'($urandom), acc);
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] cnt, input logic [W-1:0] d);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 30 && !acc; t++) begin
      tick();
      drive(1'b1, op, cnt, d, acc);
    end
    if (!acc) check("accept_timeout", 32'(0), 32'(1));
    tick();
    rand_idle_inputs();
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 30 && expq.size() > 0; t++) begin
      tick();
      rand_idle_inputs();
    end
    if (expq.size() > 0) check("idle_timeout", 32'(expq.size()), 32'(0));
    tick();
    rand_idle_inputs();
  endtask

  initial begin
    logic acc;
    logic [1:0] op;
    rst_n = 1'b0; hold = 1'b1; q_model = '0; cur_ready = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = '0; cmd_data = '0;
    #2;
    check("rst_sel",   32'(sel),       32'(0));
    check("rst_pout",  32'(p_out),     32'(0));
    check("rst_busy",  32'(busy),      32'(0));
    check("rst_done",  32'(done),      32'(0));
    check("rst_ready", 32'(cmd_ready), 32'(0));
    tick(); tick();
    rst_n = 1'b1; hold = 1'b0;

    issue(OP_LOAD, 3'd0, 4'b1010);  wait_idle(); check("q_load", 32'(q), 32'(4'b1010));
    issue(OP_SHR,  3'd2, 4'b1101);  wait_idle(); check("q_shr",  32'(q), 32'(4'b0110));
    issue(OP_SHL,  3'd3, 4'b0101);  wait_idle(); check("q_shl",  32'(q), 32'(4'b0101));

    drv_seen = 0; issue(OP_NOP, 3'd5, 4'b1111); wait_idle();
    check("nop_drive_cycles", 32'(drv_seen), 32'(0));
    drv_seen = 0; issue(OP_SHR, 3'd0, 4'b1111); wait_idle();
    check("cnt0_drive_cycles", 32'(drv_seen), 32'(0));
    drv_seen = 0; issue(OP_SHL, 3'd7, 4'b0110); wait_idle();
    check("cnt7_drive_cycles", 32'(drv_seen), 32'(4));

    // cmd_valid held high, a new command presented right after each acceptance
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      acc = 1'b0;
      for (int t = 0; t < 30 && !acc; t++) begin
        tick();
        drive(1'b1, op, 3'($urandom_range(0, 7)), W'($urandom), acc);
      end
      if (!acc) check("hs_accept_timeout", 32'(0), 32'(1));
    end
    tick(); rand_idle_inputs();
    wait_idle();

    // reset during the second drive cycle of a 4-shift command
    issue(OP_SHR, 3'd4, 4'b1011);
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_sel",   32'(sel),       32'(0));
    check("abort_busy",  32'(busy),      32'(0));
    check("abort_done",  32'(done),      32'(0));
    check("abort_ready", 32'(cmd_ready), 32'(0));
    expq.delete(); hold = 1'b1; q_model = '0;
    tick(); tick();
    rst_n = 1'b1; hold = 1'b0;
    tick(); rand_idle_inputs();
    issue(OP_LOAD, 3'd0, 4'b0011); wait_idle();
    check("q_after_abort", 32'(q), 32'(4'b0011));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
